uart_tx_periph: RTL and testbench
=================================

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, reset value of the baud divisor in clocks per bit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of TX FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_valid  input  1  bus request from the SoC core.
REQ-006 SHALL have port mem_ready  output  1  one-cycle acknowledge.
REQ-007 SHALL have port mem_addr  input  4  byte offset of the register.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_wstrb  input  4  byte strobes; 0 means read.
REQ-010 SHALL have port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-011 SHALL have port tx  output  1  UART serial line, idle high.

Function
REQ-012 Register map SHALL be: 0x0 DATA (W, byte 0 pushes FIFO); 0x4 STATUS (R: bit0 busy, bit1 full, bit2 empty, bit3 overflow; W1C bit3); 0x8 DIV (RW, bits 15:0).
REQ-013 mem_ready SHALL pulse high for exactly one cycle, in the cycle after mem_valid is first sampled high, and SHALL stay low while mem_valid is low.
REQ-014 A transaction SHALL take effect only on the mem_ready cycle; unmapped offsets SHALL read 0 and ignore writes.
REQ-015 A DATA write with mem_wstrb[0]=1 SHALL push mem_wdata[7:0]; a push while full without a simultaneous pop SHALL be dropped and set overflow.
REQ-016 A push and a pop in the same cycle while full SHALL both succeed, and overflow SHALL stay unchanged.
REQ-017 Writing 0 to DIV SHALL store 1; DIV SHALL be latched at each frame start, so a write mid-frame affects only the next frame.
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and enter START, so tx falls one clock after the push edge.
REQ-020 START, each of the 8 DATA bits (LSB first) and STOP SHALL each last exactly the latched DIV clocks, giving 10×DIV clocks per frame.
REQ-021 At the end of STOP, the FSM SHALL go directly to START (no idle gap) if the FIFO is non-empty, else to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 The bit counter and the baud counter SHALL wrap without overflow: baud counter width 16, bit index 3 bits.

Reset
REQ-024 On reset the block SHALL force tx=1, mem_ready=0, mem_rdata=0, FSM=IDLE, FIFO empty, overflow=0 and DIV=CLK_DIV.
REQ-025 Reset asserted mid-frame SHALL abort the frame, with tx=1 from the next clock edge and FIFO contents discarded.
REQ-026 Reset asserted mid-transaction SHALL suppress mem_ready for that request.

Structure
REQ-027 Package uart_pkg SHALL hold the register offsets, STATUS bit indices, the FSM state enum and the DIV width.
REQ-028 The FIFO SHALL be a separate sub-module uart_tx_fifo (push, pop, data, full, empty), with the FSM, baud counter and bus decode in the top level.

Verification
REQ-029 After reset, a STATUS read SHALL return 0x4 and a DIV read SHALL return 16.
REQ-030 With DIV=4, writing DATA 0x55 SHALL make tx 0,1,0,1,0,1,0,1,0,1, each level lasting 4 clocks, with busy high for 40 clocks.
REQ-031 Writing 0xA5 then 0x3C back-to-back SHALL produce two frames with no tx-high gap between the first STOP and the second START.
REQ-032 Five DATA writes during one active frame SHALL drop the fifth; STATUS SHALL read overflow=1 and full=1, and writing 0x8 to STATUS SHALL clear overflow.
REQ-033 Writing DIV=0 SHALL read back 1; a DIV write during a frame SHALL leave the current bit timing unchanged.
REQ-034 Reset asserted at DATA bit 3 SHALL drive tx=1 on the next edge, after which STATUS SHALL read 0x4 and no further frame follows.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit peripheral: register offsets,
// STATUS bit positions, the transmitter state enum and the divisor width.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Baud divisor register width (clocks per bit).
    localparam int DIV_W = 16;

    // Register byte offsets on the 4-bit bus address.
    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_DIV    = 4'h8;

    // STATUS register bit positions.
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    // Serial transmitter states.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous FIFO holding bytes waiting to be transmitted.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset (empties the FIFO)
//   push   - write wdata this cycle; accepted when not full, or when full
//            and a pop happens in the same cycle
//   pop    - discard the head entry (ignored when empty)
//   wdata  - entry to write
//   data   - head entry (valid while empty = 0)
//   full   - all DEPTH entries occupied
//   empty  - no entries occupied
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign data  = mem[rd_ptr];

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after it has been
    // written, so clearing it would add reset fan-out for no behaviour.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// -----------------------------------------------------------------------------
// uart_tx_periph
// Memory-mapped UART transmitter: a simple valid/ready register interface,
// a TX FIFO, a programmable baud divisor and an 8N1 serial FSM.
//
// Registers: 0x0 DATA   (W)  byte 0 pushes the FIFO
//            0x4 STATUS (R)  {overflow, empty, full, busy}; W1C overflow
//            0x8 DIV    (RW) clocks per bit, 0 is stored as 1
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset
//   mem_valid - bus request
//   mem_ready - one-cycle acknowledge, the cycle after the request is seen
//   mem_addr  - register byte offset
//   mem_wdata - write data
//   mem_wstrb - byte strobes, all zero means read
//   mem_rdata - read data, valid while mem_ready = 1
//   tx        - serial output, idle high
// -----------------------------------------------------------------------------
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        tx
);

    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(CLK_DIV);

    // Bus decode
    logic             req;
    logic             is_write;
    logic             push;
    logic             clr_ovf;
    logic             wr_div;
    logic [DIV_W-1:0] div_wr;
    logic [31:0]      read_val;
    logic [3:0]       status;

    // Peripheral state
    logic             overflow;
    logic [DIV_W-1:0] div_reg;
    logic             busy;

    // FIFO
    logic             pop;
    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;

    // Transmitter
    tx_state_e        state, state_n;
    logic [DIV_W-1:0] baud_cnt, baud_n;
    logic [DIV_W-1:0] div_lat, div_lat_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       tx_byte, tx_byte_n;
    logic             tx_n;
    logic             bit_end;
    logic             start_frame;

    // Upper write-data bits have no register behind them.
    logic             unused;
    assign unused = ^mem_wdata[31:16];

    // A request is serviced on the edge that raises mem_ready; holding
    // mem_valid through the ready cycle does not start a second access.
    assign req      = mem_valid && !mem_ready;
    assign is_write = |mem_wstrb;
    assign push     = req && is_write && (mem_addr == ADDR_DATA) && mem_wstrb[0];
    assign clr_ovf  = req && is_write && (mem_addr == ADDR_STATUS) && mem_wstrb[0]
                      && mem_wdata[STAT_OVF];
    assign wr_div   = req && is_write && (mem_addr == ADDR_DIV);

    assign div_wr = {mem_wstrb[1] ? mem_wdata[15:8] : div_reg[15:8],
                     mem_wstrb[0] ? mem_wdata[7:0]  : div_reg[7:0]};

    assign busy = (state != IDLE);

    // NOTE: every variable of a combinational block gets a default before
    // any branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        status             = '0;
        status[STAT_BUSY]  = busy;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_OVF]   = overflow;

        read_val = '0;
        case (mem_addr)
            ADDR_STATUS: read_val = {28'd0, status};
            ADDR_DIV:    read_val = {16'd0, div_reg};
            default:     read_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= req;
            mem_rdata <= (req && !is_write) ? read_val : '0;
        end
    end

    // A dropped push wins over a simultaneous clear; both cannot come from
    // the same bus access, so the order only matters for robustness.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= DIV_RESET;
        end else if (wr_div) begin
            div_reg <= (div_wr == '0) ? DIV_W'(1) : div_wr;
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (mem_wdata[7:0]),
        .data  (fifo_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Last clock of the current bit period, measured with the divisor
    // latched at frame start.
    assign bit_end = (baud_cnt == div_lat - DIV_W'(1));

    always_comb begin
        state_n     = state;
        baud_n      = baud_cnt;
        div_lat_n   = div_lat;
        bit_n       = bit_idx;
        tx_byte_n   = tx_byte;
        tx_n        = tx;
        pop         = 1'b0;
        start_frame = 1'b0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) start_frame = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    tx_n    = tx_byte[0];
                end else begin
                    baud_n = baud_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = tx_byte[bit_n];
                    end
                end else begin
                    baud_n = baud_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Shared by IDLE and back-to-back STOP: take the head byte and
        // freeze the divisor for the whole frame.
        if (start_frame) begin
            pop       = 1'b1;
            state_n   = START;
            tx_byte_n = fifo_data;
            div_lat_n = div_reg;
            baud_n    = '0;
            bit_n     = 3'd0;
            tx_n      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            div_lat  <= DIV_RESET;
            bit_idx  <= 3'd0;
            tx_byte  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            div_lat  <= div_lat_n;
            bit_idx  <= bit_n;
            tx_byte  <= tx_byte_n;
            tx       <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_periph
// Self-checking bench for uart_tx_periph. The serial line is recorded every
// cycle; expected waveforms come from a frame-level model (10 bit periods of
// DIV clocks per byte, frames packed back to back from the first start).
// -----------------------------------------------------------------------------
module tb_uart_tx_periph;

    localparam int         HIST_N   = 16384;
    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_DIV    = 4'h8;
    localparam logic [3:0] A_UNMAP  = 4'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [3:0]  mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        tx;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic hist [HIST_N];

    always #5 clk = ~clk;

    uart_tx_periph #(
        .CLK_DIV    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .tx        (tx)
    );

    // Cycle n begins at the n-th rising edge; hist[n] is tx during it.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < HIST_N) hist[cyc] = tx;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_xfer(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            output logic [31:0] rd, output int rc);
        bit seen;
        seen = 1'b0;
        rd = '0;
        rc = -1;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                seen = 1'b1;
                rd = mem_rdata;
                rc = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout addr=%h: no mem_ready within 4 cycles", a);
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = '0;
        mem_wdata = '0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws,
                             output int rc);
        logic [31:0] unused_rd;
        bus_xfer(a, wd, ws, unused_rd, rc);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] rd, output int rc);
        bus_xfer(a, 32'd0, 4'b0000, rd, rc);
    endtask

    // Reference line level at 'rel' clocks after the first start bit.
    function automatic logic model_tx(input int rel, input logic [7:0] bytes [$], input int divs [$]);
        logic [7:0] b;
        int         bit_no;
        if (rel < 0) return 1'b1;
        for (int k = 0; k < bytes.size(); k++) begin
            if (rel < 10 * divs[k]) begin
                bit_no = rel / divs[k];
                b = bytes[k];
                if (bit_no == 0) return 1'b0;
                if (bit_no == 9) return 1'b1;
                return b[bit_no-1];
            end
            rel -= 10 * divs[k];
        end
        return 1'b1;
    endfunction

    // Compares tx from one clock before 'start' to a few clocks after the
    // last stop bit against the model.
    task automatic check_frames(input int start, input logic [7:0] bytes [$], input int divs [$],
                                input string name);
        int   total;
        int   bad;
        logic exp;
        logic got;
        total = 0;
        foreach (divs[i]) total += 10 * divs[i];
        wait_until(start + total + 4);
        bad = -1000;
        exp = 1'b0;
        got = 1'b0;
        for (int c = start - 1; c < start + total + 3; c++) begin
            if (bad == -1000 && hist[c] !== model_tx(c - start, bytes, divs)) begin
                bad = c - start;
                got = hist[c];
                exp = model_tx(c - start, bytes, divs);
            end
        end
        checks++;
        if (bad != -1000) begin
            errors++;
            $display("FAIL %s: tx at frame clock %0d is %b, expected %b", name, bad, got, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int          rc;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b, expected 1", tx);
        end
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: got ready=%b rdata=%h, expected ready=0 rdata=0", mem_ready, mem_rdata);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read(A_STATUS, rd, rc);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL reset_status: got %h, expected 4", rd);
        end
        bus_read(A_DIV, rd, rc);
        checks++;
        if (rd !== 32'd16) begin
            errors++;
            $display("FAIL reset_div: got %0d, expected 16", rd);
        end
        // A request whose acknowledge edge sees reset is never acknowledged.
        mem_valid = 1'b1;
        mem_addr  = A_STATUS;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_ack: got ready=%b, expected 0", mem_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bus();
        logic [31:0] rd;
        int          rc;
        int          c0;
        bit          bad;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_ready !== 1'b0) bad = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_ready: got mem_ready=1 without request, expected 0");
        end
        c0 = cyc;
        bus_read(A_STATUS, rd, rc);
        checks++;
        if (rc !== c0 + 1) begin
            errors++;
            $display("FAIL ack_latency: ready in cycle %0d, expected %0d", rc, c0 + 1);
        end
        @(negedge clk);
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL ack_width: got ready=%b after ack cycle, expected 0", mem_ready);
        end
        @(posedge clk);
        #1;
        bus_write(A_UNMAP, 32'hFFFF_FFFF, 4'b1111, rc);
        bus_read(A_UNMAP, rd, rc);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_read: got %h, expected 0", rd);
        end
        bus_read(A_DATA, rd, rc);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL data_read: got %h, expected 0", rd);
        end
        // Byte-lane write to DIV: only byte 1 changes.
        bus_write(A_DIV, 32'h0000_03AA, 4'b0010, rc);
        bus_read(A_DIV, rd, rc);
        checks++;
        if (rd !== 32'h0000_0310) begin
            errors++;
            $display("FAIL div_strobe: got %h, expected 00000310", rd);
        end
        bus_write(A_DIV, 32'd16, 4'b0011, rc);
        // DATA write without byte 0 strobe must not push.
        bus_write(A_DATA, 32'h0000_5A5A, 4'b0010, rc);
        c0 = rc;
        wait_until(c0 + 8);
        bus_read(A_STATUS, rd, rc);
        bad = 1'b0;
        for (int c = c0; c < c0 + 8; c++) if (hist[c] !== 1'b1) bad = 1'b1;
        checks++;
        if (rd !== 32'h4 || bad) begin
            errors++;
            $display("FAIL data_no_strobe: status=%h line_disturbed=%0d, expected status=4 line idle", rd, bad);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0]  bq [$];
        int          dq [$];
        logic [31:0] rd;
        logic [31:0] exp;
        int          rc;
        int          s;
        int          smp;
        bus_write(A_DIV, 32'd4, 4'b0011, rc);
        bus_write(A_DATA, 32'h55, 4'b0001, rc);
        s = rc + 1;
        // STATUS sampled at the edge that raises ready reflects the previous cycle.
        for (int j = 0; j < 24; j++) begin
            bus_read(A_STATUS, rd, rc);
            smp = rc - 1;
            exp = (smp >= s && smp < s + 40) ? 32'h5 : 32'h4;
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL busy_window: status at frame clock %0d is %h, expected %h", smp - s, rd, exp);
            end
        end
        bq.push_back(8'h55);
        dq.push_back(4);
        check_frames(s, bq, dq, "frame_55");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bq [$];
        int         dq [$];
        int         rc;
        int         s;
        bus_write(A_DIV, 32'd4, 4'b0011, rc);
        bus_write(A_DATA, 32'hA5, 4'b0001, rc);
        s = rc + 1;
        bus_write(A_DATA, 32'h3C, 4'b0001, rc);
        bq = '{8'hA5, 8'h3C};
        dq = '{4, 4};
        check_frames(s, bq, dq, "back_to_back");
        checks++;
        if (hist[s + 39] !== 1'b1 || hist[s + 40] !== 1'b0) begin
            errors++;
            $display("FAIL frame_gap: stop/start levels %b%b, expected 10", hist[s + 39], hist[s + 40]);
        end
    endtask

    task automatic test_div();
        logic [7:0]  bq [$];
        int          dq [$];
        logic [31:0] rd;
        int          rc;
        int          s;
        bus_write(A_DIV, 32'hABCD_0000, 4'b1111, rc);
        bus_read(A_DIV, rd, rc);
        checks++;
        if (rd !== 32'd1) begin
            errors++;
            $display("FAIL div_zero: got %0d, expected 1", rd);
        end
        bus_write(A_DIV, 32'd5, 4'b0011, rc);
        bus_write(A_DATA, 32'hC3, 4'b0001, rc);
        s = rc + 1;
        bus_write(A_DIV, 32'd3, 4'b0011, rc);
        bus_write(A_DATA, 32'h81, 4'b0001, rc);
        bus_read(A_DIV, rd, rc);
        checks++;
        if (rd !== 32'd3) begin
            errors++;
            $display("FAIL div_readback: got %0d, expected 3", rd);
        end
        bq = '{8'hC3, 8'h81};
        dq = '{5, 3};
        check_frames(s, bq, dq, "div_midframe");
    endtask

    task automatic test_overflow();
        logic [7:0]  bq [$];
        int          dq [$];
        logic [7:0]  b [7];
        logic [31:0] rd;
        int          rc;
        int          s;
        for (int i = 0; i < 7; i++) b[i] = 8'($urandom);
        bus_write(A_DIV, 32'd8, 4'b0011, rc);
        bus_write(A_DATA, {24'd0, b[0]}, 4'b0001, rc);
        s = rc + 1;
        for (int i = 1; i <= 5; i++) bus_write(A_DATA, {24'd0, b[i]}, 4'b0001, rc);
        bus_read(A_STATUS, rd, rc);
        checks++;
        if (rd !== 32'hB) begin
            errors++;
            $display("FAIL overflow_set: status %h, expected b", rd);
        end
        bus_write(A_STATUS, 32'h8, 4'b0001, rc);
        bus_read(A_STATUS, rd, rc);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL overflow_clear: status %h, expected 3", rd);
        end
        // Push lands on the edge that pops the next byte while full.
        wait_until(s + 79);
        bus_write(A_DATA, {24'd0, b[6]}, 4'b0001, rc);
        bus_read(A_STATUS, rd, rc);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL push_pop_full: status %h, expected 3", rd);
        end
        bq = '{b[0], b[1], b[2], b[3], b[4], b[6]};
        dq = '{8, 8, 8, 8, 8, 8};
        check_frames(s, bq, dq, "overflow_frames");
    endtask

    task automatic test_random();
        logic [7:0]  bq [$];
        int          dq [$];
        logic [31:0] rd;
        int          rc;
        int          s;
        int          d;
        int          n;
        for (int it = 0; it < 5; it++) begin
            d = int'($urandom_range(6, 1));
            n = int'($urandom_range(3, 1));
            bus_write(A_DIV, {16'($urandom), 16'(d)}, 4'b1111, rc);
            bus_read(A_DIV, rd, rc);
            checks++;
            if (rd !== 32'(d)) begin
                errors++;
                $display("FAIL rand_div: got %0d, expected %0d", rd, d);
            end
            bq.delete();
            dq.delete();
            s = 0;
            for (int k = 0; k < n; k++) begin
                bq.push_back(8'($urandom));
                dq.push_back(d);
                bus_write(A_DATA, {24'($urandom), bq[k]}, 4'b1111, rc);
                if (k == 0) s = rc + 1;
            end
            check_frames(s, bq, dq, "rand_frames");
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int          rc;
        int          s;
        int          c0;
        bit          bad;
        bus_write(A_DIV, 32'd4, 4'b0011, rc);
        bus_write(A_DATA, 32'h08, 4'b0001, rc);
        s = rc + 1;
        bus_write(A_DATA, 32'h42, 4'b0001, rc);
        // Data bit 3 of 0x08 is 1 at frame clocks 16..19; reset there.
        wait_until(s + 17);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL bit3_level: got %b, expected 1", tx);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort_tx: got %b, expected 1", tx);
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        wait_until(c0 + 60);
        bad = 1'b0;
        for (int c = c0; c < c0 + 60; c++) if (hist[c] !== 1'b1) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_frame_after_reset: tx left idle, expected 1 throughout");
        end
        bus_read(A_STATUS, rd, rc);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL status_after_reset: got %h, expected 4", rd);
        end
        bus_read(A_DIV, rd, rc);
        checks++;
        if (rd !== 32'd16) begin
            errors++;
            $display("FAIL div_after_reset: got %0d, expected 16", rd);
        end
    endtask

    initial begin
        test_reset();
        test_bus();
        test_single_frame();
        test_back_to_back();
        test_div();
        test_overflow();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
